byte_uart_tx: RTL and testbench

Serial transmitter that consumes the CPU's memory-mapped console byte stream (out_byte / out_byte_en strobe from the system top) and sends it on a UART TX pin.
- A small synchronous FIFO decouples single-cycle CPU writes from slow serial frames.
- Frame format is 8N1, LSB first.
- Status outputs are intended for a CPU-readable status word, so firmware can poll before writing.

---
 rtl/byte_uart_tx_pkg.sv | 7 +
 rtl/byte_fifo.sv | 44 ++++
 rtl/byte_uart_tx.sv | 104 ++++++++++
 tb/tb_byte_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/byte_uart_tx_pkg.sv
// byte_uart_tx_pkg: state encoding and frame constants shared by the byte UART transmitter
package byte_uart_tx_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int FRAME_BITS = 10;
    localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 3);
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO; pushes while full and pops while empty are ignored
module byte_fifo #(
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];
    assign full   = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign empty  = r_cnt == '0;
    assign level  = r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // storage is not reset: stale entries are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/byte_uart_tx.sv
// byte_uart_tx: FIFO-buffered 8N1 UART transmitter fed by single-cycle byte strobes
module byte_uart_tx import byte_uart_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_en,
    input  logic        clr_overflow,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [AW:0] fifo_level,
    output logic        overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    state_t        r_state, w_state_nx;
    logic [BW-1:0] r_baud, w_baud_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx, w_head;
    logic          r_tx, w_tx_nx, r_ovf, w_pop, w_bit_end;

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (in_byte_en),
        .pop   (w_pop),
        .din   (in_byte),
        .dout  (w_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign w_bit_end = r_baud == BW'(CLKS_PER_BIT - 1);

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = w_bit_end ? '0 : r_baud + BW'(1);
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nx = '0;
                if (!fifo_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_state_nx = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_nx   = '0;
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nx = r_shift >> 1;
                    w_bit_nx   = r_bit + 3'd1;
                    w_state_nx = (r_bit == LAST_DATA_BIT) ? STOP : DATA;
                end
            end
            STOP: begin
                // chain straight into the next start bit so queued frames leave no gap
                if (w_bit_end) begin
                    w_pop      = !fifo_empty;
                    w_shift_nx = fifo_empty ? r_shift : w_head;
                    w_state_nx = fifo_empty ? IDLE : START;
                end
            end
        endcase
    end

    // line level is registered from the next state so tx changes only on clock edges
    assign w_tx_nx = (w_state_nx == START) ? 1'b0 : (w_state_nx == DATA) ? w_shift_nx[0] : 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
            r_ovf   <= (in_byte_en && fifo_full) || (r_ovf && !clr_overflow);
        end
    end

    assign tx       = r_tx;
    assign busy     = r_state != IDLE;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_byte_uart_tx.sv
// tb_byte_uart_tx: directed checks of byte_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4
module tb_byte_uart_tx;
    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_byte_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       tx, busy, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_level;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_frame_err = 0;
    logic [7:0] rxq [$];

    byte_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_byte     (in_byte),
        .in_byte_en  (in_byte_en),
        .clr_overflow(clr_overflow),
        .tx          (tx),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    // independent line receiver: samples each bit in its middle, 4 clocks per bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (resetn && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (4) @(negedge clk);
                    b[k] = tx;
                end
                repeat (4) @(negedge clk);
                if (tx !== 1'b1) n_frame_err++;
                rxq.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        in_byte = b;
        in_byte_en = 1'b1;
        @(negedge clk);
        in_byte_en = 1'b0;
    endtask

    // called on the first negedge showing the start bit; returns 40 cycles later
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic e;
        for (int i = 0; i < 10; i++) begin
            e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            for (int j = 0; j < 4; j++) begin
                chk({tag, "_tx"}, 32'(tx), 32'(e));
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_busy(input int max, input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic chk_rx(input logic [7:0] exp [], input string tag);
        chk({tag, "_count"}, rxq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rxq[i]), 32'(exp[i]));
        rxq.delete();
    endtask

    initial begin
        int bad;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // single byte: tx falls on the edge after the push edge
        push(8'h55);
        chk("single_pre_tx", 32'(tx), 32'd1);
        chk("single_pre_level", 32'(fifo_level), 32'd1);
        @(negedge clk);
        chk("single_empty", 32'(fifo_empty), 32'd1);
        expect_frame(8'h55, "single");
        chk("single_end_busy", 32'(busy), 32'd0);
        chk("single_end_tx", 32'(tx), 32'd1);
        rxq.delete();
        repeat (3) @(negedge clk);

        // back-to-back frames with no idle gap
        push(8'h41);
        push(8'h42);
        expect_frame(8'h41, "b2b0");
        expect_frame(8'h42, "b2b1");
        chk("b2b_end_busy", 32'(busy), 32'd0);
        chk_rx('{8'h41, 8'h42}, "b2b_rx");
        repeat (3) @(negedge clk);

        // overflow and clear race
        push(8'h00);
        wait_busy(10, 1'b1, "ovf_start");
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        in_byte = 8'h66;
        in_byte_en = 1'b1;
        clr_overflow = 1'b1;
        @(negedge clk);
        in_byte_en = 1'b0;
        chk("race_ovf", 32'(overflow), 32'd1);
        chk("race_level", 32'(fifo_level), 32'd4);
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        wait_busy(400, 1'b0, "ovf_idle");
        chk("ovf_empty", 32'(fifo_empty), 32'd1);
        chk_rx('{8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, "ovf_rx");
        repeat (3) @(negedge clk);

        // reset during DATA bit 3 (0xA5 bit 3 is 0, so tx is low there)
        push(8'hA5);
        @(negedge clk);
        chk("mid_start_tx", 32'(tx), 32'd0);
        repeat (16) @(negedge clk);
        chk("mid_bit3_tx", 32'(tx), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("post_rst_idle_samples", 32'(bad), 32'd0);
        rxq.delete();

        // push coinciding with the STOP-end pop keeps the level
        push(8'h12);
        push(8'h34);
        push(8'h56);
        chk("sim_level_pre", 32'(fifo_level), 32'd2);
        repeat (38) @(negedge clk);
        chk("sim_level_stop", 32'(fifo_level), 32'd2);
        push(8'h78);
        chk("sim_level_post", 32'(fifo_level), 32'd2);
        chk("sim_next_start", 32'(tx), 32'd0);
        chk("sim_busy", 32'(busy), 32'd1);
        wait_busy(400, 1'b0, "sim_idle");
        chk_rx('{8'h12, 8'h34, 8'h56, 8'h78}, "sim_rx");
        chk("stop_bit_errors", 32'(n_frame_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
